// File: rtl/secjmp_tagger.sv
// rtl/secjmp_tagger.sv - tags committed MIPS jumps against a shadow return stack
// Output is {tag, instr}; a nonzero tag marks a jump the downstream filter must block.
module secjmp_tagger #(
    parameter int DEPTH     = 8,
    parameter bit ALLOW_IND = 1'b0,
    parameter int CNT_W     = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_instr,
    input  logic [31:0]      in_pc,
    input  logic [31:0]      in_rs_val,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [63:0]      out_word,
    output logic [CNT_W-1:0] viol_cnt,
    output logic             ovf_sticky
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [AW:0] FULL = DEPTH[AW:0];

    localparam logic [3:0] CAUSE_OK       = 4'd0;
    localparam logic [3:0] CAUSE_MISMATCH = 4'd1;
    localparam logic [3:0] CAUSE_EMPTY    = 4'd2;
    localparam logic [3:0] CAUSE_INDIRECT = 4'd3;

    logic [31:0]   stk [DEPTH];
    logic [AW-1:0] wp;
    logic [AW:0]   occ;

    logic [5:0]  op;
    logic [5:0]  fn;
    logic [4:0]  rs;
    logic [4:0]  rd;
    logic        is_jal;
    logic        is_jalr;
    logic        is_jr;
    logic        is_ret;
    logic        stk_empty;
    logic        do_push;
    logic        do_pop;
    logic        accept;
    logic [AW-1:0] top_idx;
    logic [31:0] top_val;
    logic [31:0] push_val;
    logic [3:0]  cause;

    assign op = in_instr[31:26];
    assign fn = in_instr[5:0];
    assign rs = in_instr[25:21];
    assign rd = in_instr[15:11];

    assign is_jal  = (op == 6'd3);
    assign is_jalr = (op == 6'd0) && (fn == 6'd9);
    assign is_jr   = (op == 6'd0) && (fn == 6'd8);
    assign is_ret  = is_jr && (rs == 5'd31);

    assign stk_empty = (occ == '0);
    assign do_push   = is_jal || (is_jalr && (rd != 5'd0));
    assign do_pop    = is_ret && !stk_empty;

    // wp is the next write slot, so the newest entry sits just below it
    assign top_idx  = wp - 1'b1;
    assign top_val  = stk[top_idx];
    assign push_val = in_pc + 32'd8;

    assign in_ready = !out_valid || out_ready;
    assign accept   = in_valid && in_ready;

    always_comb begin
        cause = CAUSE_OK;
        if (is_ret) begin
            if (stk_empty)
                cause = CAUSE_EMPTY;
            else if (top_val != in_rs_val)
                cause = CAUSE_MISMATCH;
        end else if (is_jr && !ALLOW_IND) begin
            cause = CAUSE_INDIRECT;
        end
    end

    // Entry storage needs no reset; occupancy alone says what is valid
    always_ff @(posedge clk) begin
        if (accept && do_push)
            stk[wp] <= push_val;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            out_word   <= '0;
            viol_cnt   <= '0;
            ovf_sticky <= 1'b0;
            wp         <= '0;
            occ        <= '0;
        end else begin
            if (accept) begin
                out_valid <= 1'b1;
                out_word  <= {28'd0, cause, in_instr};
                if ((cause != CAUSE_OK) && (viol_cnt != '1))
                    viol_cnt <= viol_cnt + 1'b1;
                if (do_push) begin
                    // When full the write slot holds the oldest entry, which is overwritten
                    wp <= wp + 1'b1;
                    if (occ == FULL)
                        ovf_sticky <= 1'b1;
                    else
                        occ <= occ + 1'b1;
                end else if (do_pop) begin
                    wp  <= top_idx;
                    occ <= occ - 1'b1;
                end
            end else if (out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_secjmp_tagger.sv
// tb/tb_secjmp_tagger.sv - scoreboard bench for secjmp_tagger (strict and permissive instances)
module tb_secjmp_tagger;
    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [31:0] in_rs_val;
    logic        out_ready;

    logic        in_ready0, in_ready1;
    logic        out_valid0, out_valid1;
    logic [63:0] out_word0, out_word1;
    logic [15:0] viol0;
    logic [2:0]  viol1;
    logic        ovf0, ovf1;

    int n_chk = 0;
    int n_fail = 0;
    int ready_mode = 0;

    logic [31:0] mstk[$];
    logic [63:0] q0[$];
    logic [63:0] q1[$];
    int  vc0 = 0;
    int  vc1 = 0;
    bit  movf = 0;

    secjmp_tagger #(.DEPTH(8), .ALLOW_IND(1'b0), .CNT_W(16)) dut0 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs_val(in_rs_val),
        .out_valid(out_valid0), .out_ready(out_ready), .out_word(out_word0),
        .viol_cnt(viol0), .ovf_sticky(ovf0)
    );

    secjmp_tagger #(.DEPTH(8), .ALLOW_IND(1'b1), .CNT_W(3)) dut1 (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready1),
        .in_instr(in_instr), .in_pc(in_pc), .in_rs_val(in_rs_val),
        .out_valid(out_valid1), .out_ready(out_ready), .out_word(out_word1),
        .viol_cnt(viol1), .ovf_sticky(ovf1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
        end
    endtask

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (ready_mode)
                0:       out_ready = 1'b1;
                1:       out_ready = (($urandom % 3) != 0);
                default: out_ready = 1'b0;
            endcase
        end
    end

    // Monitor and reference model: outputs checked against the queue heads, then any accept applied
    always @(negedge clk) begin
        if (rst_n) begin
            logic        exp_ready;
            logic [31:0] i, p, r, popped;
            logic [5:0]  op, fn;
            logic [4:0]  rs, rd;
            logic [3:0]  c0, c1;
            exp_ready = (q0.size() == 0) || out_ready;
            chk("out_valid0", {63'd0, out_valid0}, {63'd0, q0.size() != 0});
            chk("out_valid1", {63'd0, out_valid1}, {63'd0, q1.size() != 0});
            chk("in_ready0", {63'd0, in_ready0}, {63'd0, exp_ready});
            chk("in_ready1", {63'd0, in_ready1}, {63'd0, exp_ready});
            chk("viol_cnt0", {48'd0, viol0}, 64'(vc0));
            chk("viol_cnt1", {61'd0, viol1}, 64'(vc1));
            chk("ovf0", {63'd0, ovf0}, {63'd0, movf});
            chk("ovf1", {63'd0, ovf1}, {63'd0, movf});
            if (q0.size() != 0 && q1.size() != 0) begin
                chk("out_word0", out_word0, q0[0]);
                chk("out_word1", out_word1, q1[0]);
                if (out_ready) begin
                    void'(q0.pop_front());
                    void'(q1.pop_front());
                end
            end
            if (in_valid && exp_ready) begin
                i = in_instr; p = in_pc; r = in_rs_val;
                op = i[31:26]; fn = i[5:0]; rs = i[25:21]; rd = i[15:11];
                c0 = 4'd0; c1 = 4'd0;
                if (op == 6'd3 || (op == 6'd0 && fn == 6'd9 && rd != 5'd0)) begin
                    mstk.push_back(p + 32'd8);
                    if (mstk.size() > 8) begin
                        void'(mstk.pop_front());
                        movf = 1'b1;
                    end
                end else if (op == 6'd0 && fn == 6'd8) begin
                    if (rs == 5'd31) begin
                        if (mstk.size() == 0) begin
                            c0 = 4'd2;
                        end else begin
                            popped = mstk.pop_back();
                            c0 = (popped == r) ? 4'd0 : 4'd1;
                        end
                        c1 = c0;
                    end else begin
                        c0 = 4'd3;
                    end
                end
                q0.push_back({28'd0, c0, i});
                q1.push_back({28'd0, c1, i});
                if (c0 != 0 && vc0 < 65535) vc0++;
                if (c1 != 0 && vc1 < 7) vc1++;
            end
        end
    end

    // Offers one word; returns at the negedge before the edge that accepts it
    task automatic send(input logic [31:0] i, input logic [31:0] p, input logic [31:0] r,
                        input bit use_top);
        int n;
        @(posedge clk);
        #1;
        if (use_top && mstk.size() != 0 && ($urandom % 4) != 0)
            r = mstk[$];
        in_valid = 1'b1; in_instr = i; in_pc = p; in_rs_val = r;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(in_ready0 && out_ready && out_valid0 || !out_valid0) && n < 200);
        if (n >= 200) chk("send_timeout", 64'd1, 64'd0);
    endtask

    task automatic drain();
        int n;
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        n = 0;
        while (q0.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) chk("drain_timeout", 64'd1, 64'd0);
    endtask

    task automatic reset_model();
        mstk.delete(); q0.delete(); q1.delete();
        vc0 = 0; vc1 = 0; movf = 1'b0;
    endtask

    initial begin
        logic [31:0] w, pc;
        int k;
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; in_rs_val = '0;
        out_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid0", {63'd0, out_valid0}, 64'd0);
        chk("rst_out_valid1", {63'd0, out_valid1}, 64'd0);
        chk("rst_out_word0", out_word0, 64'd0);
        chk("rst_viol0", {48'd0, viol0}, 64'd0);
        chk("rst_viol1", {61'd0, viol1}, 64'd0);
        chk("rst_ovf0", {63'd0, ovf0}, 64'd0);
        rst_n = 1'b1;

        send(32'h00851021, 32'h00400000, 32'h0, 1'b0);
        send(32'h0C100040, 32'h00400100, 32'h0, 1'b0);
        send(32'h03E00008, 32'h00400120, 32'h00400108, 1'b0);
        send(32'h0C100040, 32'h00400100, 32'h0, 1'b0);
        send(32'h03E00008, 32'h00400120, 32'h00400200, 1'b0);
        send(32'h03E00008, 32'h00400124, 32'h00400108, 1'b0);
        send(32'h01000008, 32'h00400130, 32'h00400108, 1'b0);
        drain();

        for (k = 0; k < 9; k++)
            send(32'h0C000400, 32'h1000 + 32'(16 * k), 32'h0, 1'b0);
        for (k = 8; k >= 1; k--)
            send(32'h03E00008, 32'h2000, 32'h1000 + 32'(16 * k) + 32'd8, 1'b0);
        send(32'h03E00008, 32'h2004, 32'h1018, 1'b0);
        drain();

        ready_mode = 2;
        send(32'h00851021, 32'h3000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_instr = 32'h0C000800; in_pc = 32'h3004;
        @(negedge clk);
        w = out_word0[31:0];
        repeat (5) begin
            @(negedge clk);
            chk("stall_in_ready", {63'd0, in_ready0}, 64'd0);
            chk("stall_word", {32'd0, out_word0[31:0]}, {32'd0, w});
        end
        ready_mode = 0;
        send(32'h0C000800, 32'h3004, 32'h0, 1'b0);
        send(32'h03E00008, 32'h3010, 32'h300C, 1'b0);
        drain();

        ready_mode = 1;
        for (int n = 0; n < 400; n++) begin
            pc = $urandom & 32'hFFFF_FFFC;
            case ($urandom % 8)
                0, 1: w = {6'h08, 26'($urandom)};
                2:    w = {6'h02, 26'($urandom)};
                3:    w = {6'h03, 26'($urandom)};
                4:    w = {6'h00, 5'($urandom), 5'd0, (($urandom % 3) == 0) ? 5'd0 : 5'($urandom), 5'd0, 6'h09};
                5, 6: w = 32'h03E00008;
                default: w = {6'h00, 5'($urandom), 15'd0, 6'h08};
            endcase
            send(w, pc, $urandom, 1'b1);
        end
        drain();

        ready_mode = 2;
        send(32'h0C000900, 32'h5000, 32'h0, 1'b0);
        @(posedge clk);
        #1;
        in_valid = 1'b1; in_instr = 32'h03E00008; in_pc = 32'h5004;
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("midrst_out_valid0", {63'd0, out_valid0}, 64'd0);
        chk("midrst_out_valid1", {63'd0, out_valid1}, 64'd0);
        chk("midrst_viol0", {48'd0, viol0}, 64'd0);
        chk("midrst_viol1", {61'd0, viol1}, 64'd0);
        chk("midrst_ovf0", {63'd0, ovf0}, 64'd0);
        reset_model();
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ready_mode = 0;
        send(32'h00851021, 32'h6000, 32'h0, 1'b0);
        send(32'h03E00008, 32'h6004, 32'h5008, 1'b0);
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule

// File: doc/secjmp_tagger.md
Name: secjmp_tagger

Overview:
- Producer-side companion to the secure-jump filter.
- Takes the committed instruction stream, classifies MIPS jumps and checks returns against a hardware shadow return stack.
- Emits 64-bit tagged words: {tag[31:0], instr[31:0]}. A tag of zero means approved, and the downstream filter passes jumps only when the tag is zero.
- Sits between the commit stage and the secure-jump filter, with valid/ready on both sides.

Parameters:
- DEPTH, 8: shadow return-stack entries; power of two, 2..64.
- ALLOW_IND, 0: 1 = jr through a register other than $31 is tagged OK; 0 = tagged cause 3.
- CNT_W, 16: width of the violation counter.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  upstream word valid.
- in_ready  output  1  block can accept a word this cycle.
- in_instr  input  32  instruction word.
- in_pc  input  32  PC of in_instr.
- in_rs_val  input  32  resolved value of rs (the jump target for jr/jalr).
- out_valid  output  1  tagged word valid.
- out_ready  input  1  downstream accepts the word.
- out_word  output  64  {tag, instr}.
- viol_cnt  output  CNT_W  saturating count of words emitted with a nonzero tag.
- ovf_sticky  output  1  shadow stack overflowed since reset.

Behaviour:
- Reset is asynchronous, active-low; reset values:
  - out_valid=0, out_word=0, viol_cnt=0, ovf_sticky=0.
  - stack pointer sp=0 (empty); stack contents don't-care.
- Handshake:
  - Transfer in when in_valid & in_ready; transfer out when out_valid & out_ready.
  - in_ready = !out_valid | out_ready.
  - Single output register, latency 1 cycle; full throughput when out_ready=1.
  - out_word is held stable while out_valid & !out_ready.
- Decode (op=instr[31:26], fn=instr[5:0], rs=instr[25:21], rd=instr[15:11]):
  - JAL: op=3.
  - J: op=2.
  - JALR: op=0, fn=9.
  - JR: op=0, fn=8.
  - Everything else is non-jump.
- Tag on accept: tag[3:0] is the cause, tag[31:4]=0.
  - Non-jump and J: cause 0.
  - JAL, and JALR with rd≠0: push in_pc+8 (mod 2^32, delay slot), cause 0.
  - JALR with rd=0: no push, cause 0.
  - JR with rs=31, stack non-empty: pop. Cause 0 if popped value == in_rs_val, else cause 1. The pop happens even on a mismatch.
  - JR with rs=31, stack empty: no pop, cause 2.
  - JR with rs≠31: no stack access; cause 0 if ALLOW_IND=1, else cause 3.
- Stack:
  - Circular buffer of DEPTH entries with an occupancy count 0..DEPTH.
  - Push when full: overwrite the oldest entry, occupancy stays DEPTH, ovf_sticky<=1.
  - Pop decrements occupancy and returns the most recent entry.
  - Stack updates only on an accepted input; a stalled output never alters the stack.
- viol_cnt: +1 per accepted word with cause≠0; saturates at 2^CNT_W-1.
- Reset mid-stream: the in-flight output is dropped, the stack empties, and counters clear immediately (asynchronous).
- Simultaneous out transfer and in accept: the output register is reloaded the same cycle, with no bubble.

Test Plan:
1. Reset, then push ADDU 0x00851021 → out_word=0x00000000_00851021 one cycle later; viol_cnt=0.
2. JAL at pc=0x400100, then JR $31 (0x03E00008) with rs_val=0x400108 → both tags 0; stack empty afterwards.
3. JAL at pc=0x400100, then JR $31 with rs_val=0x400200 → tag=1 on the JR; viol_cnt=1; a following JR $31 → tag=2 (empty).
4. ALLOW_IND=0: JR $8 (0x01000008) → tag=3. ALLOW_IND=1: same word → tag 0, stack untouched.
5. DEPTH=8: 9 JALs at pc=0x1000+16k (k=0..8), then 8 JR $31 with the matching LIFO targets 0x1088 down to 0x1018 → all tags 0, ovf_sticky=1; 9th JR → tag=2.
6. Hold out_ready=0 for 5 cycles with in_valid=1 → in_ready=0 and out_word stable, no stack change; assert rst_n=0 mid-stall → out_valid=0 and viol_cnt=0 immediately.
